// File: rtl/flash_audio_fetch_if.sv
// flash_audio_fetch_if: Avalon-MM-style word read bus between the audio fetcher and flash
// read/address: request from master, held until waitrequest is low
// waitrequest: slave stall; readdatavalid/readdata: returned word strobe and data
interface flash_audio_fetch_if #(parameter int ADDR_W = 23);
  logic read;
  logic [ADDR_W-1:0] address;
  logic waitrequest;
  logic readdatavalid;
  logic [31:0] readdata;
  modport master(output read, address, input waitrequest, readdatavalid, readdata);
  modport slave(input read, address, output waitrequest, readdatavalid, readdata);
endinterface

// File: rtl/flash_audio_fetch.sv
// flash_audio_fetch: walks the flash audio region one word at a time and steps a byte select per sample tick
// clk/reset_n: clock and async active-low reset
// sample_tick/direction/pause/restart: playback controls
// flash: read bus master; audio_data/select/finish: current word, byte index, new-word pulse
// underrun: pulse when a tick is dropped while a word is being fetched
module flash_audio_fetch #(
  parameter int ADDR_W = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR = 23'h07FFFF
) (
  input logic clk,
  input logic reset_n,
  input logic sample_tick,
  input logic direction,
  input logic pause,
  input logic restart,
  flash_audio_fetch_if.master flash,
  output logic [31:0] audio_data,
  output logic [1:0] select,
  output logic finish,
  output logic underrun
);
  typedef enum logic [1:0] {FETCH_REQ, FETCH_WAIT, PLAY} state_t;
  state_t state;
  logic rd, pend, discard, accept, tick, last;
  logic [ADDR_W-1:0] addr, pend_addr, restart_addr, step_addr;
  assign flash.read = rd;
  assign flash.address = addr;
  always_comb begin
    accept = rd && !flash.waitrequest;
    tick = sample_tick && !pause && !restart;
    last = select == (direction ? 2'd3 : 2'd0);
    restart_addr = direction ? START_ADDR : END_ADDR;
    step_addr = direction ? (addr == END_ADDR ? START_ADDR : addr + ADDR_W'(1))
                          : (addr == START_ADDR ? END_ADDR : addr - ADDR_W'(1));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= FETCH_REQ;
      addr <= START_ADDR;
      pend_addr <= START_ADDR;
      pend <= 1'b0;
      discard <= 1'b0;
      rd <= 1'b0;
      audio_data <= '0;
      select <= '0;
      finish <= 1'b0;
      underrun <= 1'b0;
    end else begin
      finish <= 1'b0;
      underrun <= tick && state != PLAY;
      case (state)
        FETCH_REQ: begin
          rd <= !accept;
          if (accept) begin
            state <= FETCH_WAIT;
            discard <= pend || restart;
            pend <= 1'b0;
            addr <= restart ? restart_addr : pend ? pend_addr : addr;
          end else if (restart && rd) begin
            pend <= 1'b1;
            pend_addr <= restart_addr;
          end else if (restart) addr <= restart_addr;
        end
        FETCH_WAIT: begin
          if (restart) begin
            addr <= restart_addr;
            discard <= 1'b1;
          end
          if (flash.readdatavalid && (discard || restart)) begin
            state <= FETCH_REQ;
            rd <= 1'b1;
            discard <= 1'b0;
          end else if (flash.readdatavalid) begin
            audio_data <= flash.readdata;
            select <= direction ? 2'd0 : 2'd3;
            finish <= 1'b1;
            state <= PLAY;
          end
        end
        default:
          if (restart || (tick && last)) begin
            addr <= restart ? restart_addr : step_addr;
            state <= FETCH_REQ;
            rd <= 1'b1;
          end else if (tick) select <= direction ? select + 2'd1 : select - 2'd1;
      endcase
    end
endmodule

// File: tb/tb_flash_audio_fetch.sv
// tb_flash_audio_fetch: directed plus randomized checks of flash_audio_fetch against a word/byte-level model
module tb_flash_audio_fetch;
  localparam int AW = 23;
  localparam logic [AW-1:0] S = 23'h000000;
  localparam logic [AW-1:0] E = 23'h07FFFF;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic sample_tick = 1'b0;
  logic direction = 1'b1;
  logic pause = 1'b0;
  logic restart = 1'b0;
  logic [31:0] audio_data;
  logic [1:0] select;
  logic finish, underrun;
  int checks = 0, errors = 0;
  logic [AW-1:0] m_addr;
  int m_sel;
  logic [31:0] m_data, d;
  flash_audio_fetch_if #(.ADDR_W(AW)) bus ();
  flash_audio_fetch #(.ADDR_W(AW), .START_ADDR(S), .END_ADDR(E)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .direction(direction),
    .pause(pause), .restart(restart), .flash(bus), .audio_data(audio_data),
    .select(select), .finish(finish), .underrun(underrun)
  );
  always #10 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic fwd);
    int span = int'(E) - int'(S) + 1;
    int off = int'(a) - int'(S) + (fwd ? 1 : span - 1);
    return AW'(int'(S) + off % span);
  endfunction
  task automatic pulse_tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask
  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask
  task automatic accept(input logic [AW-1:0] a, input int waits);
    for (int i = 0; i < 50 && !bus.read; i++) step();
    check("read_rise", bus.read, 1);
    check("req_addr", bus.address, a);
    for (int i = 0; i < waits; i++) begin
      step();
      check("stall_read", bus.read, 1);
      check("stall_addr", bus.address, a);
    end
    bus.waitrequest = 1'b0;
    step();
    bus.waitrequest = 1'b1;
    check("read_drop", bus.read, 0);
  endtask
  task automatic deliver(input logic [31:0] w, input int lat);
    for (int i = 1; i < lat; i++) step();
    bus.readdatavalid = 1'b1;
    bus.readdata = w;
    step();
    bus.readdatavalid = 1'b0;
    bus.readdata = $urandom;
  endtask
  task automatic got_word(input logic [31:0] w, input int sel);
    check("finish", finish, 1);
    check("audio_data", audio_data, w);
    check("select_latch", select, sel);
    step();
    check("finish_pulse", finish, 0);
  endtask
  task automatic do_fetch();
    bit disc;
    logic [31:0] w;
    int k;
    do begin
      accept(m_addr, $urandom_range(0, 3));
      disc = 0;
      k = $urandom_range(0, 5);
      if (k == 0) begin
        pulse_tick();
        check("rand_underrun", underrun, !pause);
        check("rand_underrun_sel", select, m_sel);
      end else if (k == 1) begin
        m_addr = direction ? S : E;
        pulse_restart();
        disc = 1;
      end
      w = $urandom;
      deliver(w, $urandom_range(1, 3));
      if (disc) begin
        check("rand_discard_finish", finish, 0);
        check("rand_discard_data", audio_data, m_data);
      end
    end while (disc);
    m_data = w;
    m_sel = direction ? 0 : 3;
    got_word(w, m_sel);
  endtask
  initial begin
    bus.waitrequest = 1'b1;
    bus.readdatavalid = 1'b0;
    bus.readdata = '0;
    reset_n = 1'b0;
    step();
    step();
    check("rst_read", bus.read, 0);
    check("rst_audio", audio_data, 0);
    check("rst_select", select, 0);
    check("rst_finish", finish, 0);
    check("rst_underrun", underrun, 0);
    reset_n = 1'b1;
    accept(S, 2);
    deliver(32'hDDCCBBAA, 1);
    got_word(32'hDDCCBBAA, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse_tick();
      check("fwd_select", select, i);
    end
    pulse_tick();
    check("fwd_next_read", bus.read, 1);
    check("fwd_next_addr", bus.address, S + 1);
    check("fwd_select_hold", select, 3);
    accept(S + 1, 1);
    d = $urandom;
    deliver(d, 2);
    got_word(d, 0);
    pulse_tick();
    check("pre_pause_sel", select, 1);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      check("pause_sel", select, 1);
      check("pause_read", bus.read, 0);
      check("pause_underrun", underrun, 0);
    end
    pause = 1'b0;
    pulse_tick();
    check("unpause_sel", select, 2);
    pulse_tick();
    pulse_tick();
    accept(S + 2, 0);
    pulse_tick();
    check("underrun", underrun, 1);
    check("underrun_sel", select, 3);
    step();
    check("underrun_pulse", underrun, 0);
    pulse_restart();
    deliver(32'hDEADBEEF, 2);
    check("restart_finish", finish, 0);
    check("restart_data", audio_data, d);
    accept(S, 1);
    deliver(32'h01234567, 1);
    got_word(32'h01234567, 0);
    direction = 1'b0;
    pulse_restart();
    accept(E, 1);
    deliver(32'h44332211, 1);
    got_word(32'h44332211, 3);
    for (int i = 2; i >= 0; i--) begin
      pulse_tick();
      check("bwd_select", select, i);
    end
    pulse_tick();
    accept(E - 1, 0);
    d = $urandom;
    deliver(d, 1);
    got_word(d, 3);
    direction = 1'b1;
    pulse_restart();
    accept(S, 0);
    d = $urandom;
    deliver(d, 1);
    got_word(d, 0);
    direction = 1'b0;
    pulse_tick();
    accept(E, 1);
    direction = 1'b1;
    d = $urandom;
    deliver(d, 1);
    got_word(d, 0);
    for (int i = 0; i < 4; i++) pulse_tick();
    check("fwd_wrap_read", bus.read, 1);
    check("fwd_wrap_addr", bus.address, S);
    direction = 1'b0;
    pulse_restart();
    check("pend_addr", bus.address, S);
    check("pend_read", bus.read, 1);
    step();
    check("pend_addr_hold", bus.address, S);
    bus.waitrequest = 1'b0;
    step();
    bus.waitrequest = 1'b1;
    check("pend_accept_drop", bus.read, 0);
    deliver(32'hCAFEF00D, 1);
    check("pend_discard_finish", finish, 0);
    check("pend_discard_data", audio_data, d);
    accept(E, 0);
    d = $urandom;
    deliver(d, 1);
    got_word(d, 3);
    m_addr = E;
    m_sel = 3;
    m_data = d;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: direction = ~direction;
        1: pause = ~pause;
        2: begin
          m_addr = direction ? S : E;
          pulse_restart();
          check("rand_restart_read", bus.read, 1);
          do_fetch();
        end
        default: begin
          pulse_tick();
          if (pause) begin
            check("rand_pause_sel", select, m_sel);
            check("rand_pause_read", bus.read, 0);
            check("rand_pause_underrun", underrun, 0);
          end else if (m_sel == (direction ? 3 : 0)) begin
            m_addr = nxt(m_addr, direction);
            check("rand_fetch_read", bus.read, 1);
            do_fetch();
          end else begin
            m_sel += direction ? 1 : -1;
            check("rand_sel", select, m_sel);
            check("rand_read", bus.read, 0);
          end
        end
      endcase
    end
    pause = 1'b0;
    direction = 1'b1;
    pulse_restart();
    check("mid_hs_read", bus.read, 1);
    #3 reset_n = 1'b0;
    #1;
    check("async_read", bus.read, 0);
    check("async_select", select, 0);
    check("async_audio", audio_data, 0);
    step();
    reset_n = 1'b1;
    accept(S, 0);
    check("post_rst_select", select, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_audio_fetch.md
Name: flash_audio_fetch

Overview:
- Upstream feeder for the audio byte-output stage.
- Walks a word address through the audio region of flash and issues one 32-bit read per word over an Avalon-MM-style read handshake.
- Latches each returned word and steps a 2-bit byte select on every sample tick. audio_data/select/finish feed the output stage directly.
- Handles direction (forward/backward), pause, restart and region wrap-around.

Parameters:
ADDR_W, 23, flash word-address width
START_ADDR, 23'h000000, first word of audio region
END_ADDR, 23'h07FFFF, last word of audio region (inclusive; END_ADDR > START_ADDR)

Ports:
clk  input  1  system clock (50 MHz); all logic on rising edge
reset_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-clk pulse per audio sample, already in clk domain
direction  input  1  1 = forward, 0 = backward
pause  input  1  1 = freeze playback
restart  input  1  one-clk pulse; jump to region start (fwd) or end (bwd)
flash_read  output  1  read request
flash_address  output  ADDR_W  word address of request
flash_waitrequest  input  1  slave stall; request accepted in cycle where read=1 and waitrequest=0
flash_readdatavalid  input  1  read data valid strobe
flash_readdata  input  32  returned word
audio_data  output  32  latched current word
select  output  2  current byte index within audio_data
finish  output  1  one-clk pulse when a new word is latched
underrun  output  1  one-clk pulse when a sample_tick is dropped during a fetch

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH_REQ; word address=START_ADDR.
  - flash_read=0, audio_data=0, select=0, finish=0, underrun=0.
  - First word request is issued the cycle after reset_n deasserts.
- States:
  - FETCH_REQ: flash_read=1, flash_address=current address, both held stable until the accept cycle (waitrequest=0). Then flash_read=0 next cycle → FETCH_WAIT.
  - FETCH_WAIT: flash_read=0. On readdatavalid:
    - audio_data<=readdata.
    - select<=2'b00 if direction=1, else 2'b11 (direction sampled in this cycle).
    - finish=1 for exactly that next cycle.
    - → PLAY.
  - PLAY: on sample_tick with pause=0:
    - If select is not at the last byte for the current direction: select<=select+1 (fwd) or select-1 (bwd).
    - If select is at the last byte (3 fwd / 0 bwd): advance address, → FETCH_REQ; select and audio_data hold.
- Address advance:
  - fwd: END_ADDR→START_ADDR, else +1.
  - bwd: START_ADDR→END_ADDR, else -1.
  - No other wrap; ADDR_W arithmetic never overflows the region.
- Direction change mid-word: applies at the next tick. Stepping reverses from the current select; last-byte test uses the new direction.
- Pause:
  - Ticks ignored in PLAY; select/address frozen; underrun not raised.
  - An in-flight fetch still completes and latches.
  - Pause never drops flash_read mid-handshake.
- Ticks arriving in FETCH_REQ/FETCH_WAIT with pause=0: dropped, underrun=1 next cycle; select not changed.
- restart:
  - Address<=START_ADDR (direction=1) or END_ADDR (direction=0); → FETCH_REQ.
  - If a request is pending (FETCH_REQ, not yet accepted): keep flash_read=1 and switch flash_address only after acceptance. The accepted request's data is discarded and the restart address is then requested.
  - If in FETCH_WAIT: the outstanding readdatavalid is consumed and discarded, no finish, then FETCH_REQ with the new address.
  - restart beats sample_tick in the same cycle; restart works while paused.
- Exactly one outstanding read at a time; readdatavalid outside FETCH_WAIT is ignored.
- Outputs are registered; no combinational path input→output.

Test Plan:
- Reset then forward play:
  - Stimulus: START=0; slave returns 32'hDDCCBBAA for addr 0 with 2 waitrequest cycles + 1 latency; 4 ticks.
  - Required: flash_address=0 held through stall; finish one pulse; audio_data=DDCCBBAA; select 0,1,2,3; 4th tick issues read at addr 1.
- Backward wrap:
  - Stimulus: direction=0, restart; slave returns 32'h44332211 at END_ADDR.
  - Required: address=END_ADDR; select 3,2,1,0; next fetch addr END_ADDR-1.
  - Then: set address to START_ADDR and consume word.
  - Required: next request at END_ADDR.
- Forward wrap:
  - Stimulus: consume all bytes at END_ADDR with direction=1.
  - Required: next flash_address=START_ADDR.
- Pause:
  - Stimulus: pause=1 at select=1; 10 ticks; release; 1 tick.
  - Required: select stays 1, no flash_read, no underrun; then select=2.
- Underrun and restart during fetch:
  - Stimulus: tick during FETCH_WAIT.
  - Required: underrun pulse, select unchanged.
  - Stimulus: restart during FETCH_WAIT (data 32'hDEADBEEF).
  - Required: DEADBEEF discarded, no finish, new request at START_ADDR.
- Async reset mid-handshake:
  - Stimulus: assert reset_n=0 while flash_read=1, then release.
  - Required: flash_read drops immediately; after release, request at START_ADDR, select=0.
